mem_port_arbiter: RTL and testbench

Single-port memory arbiter and sequencer for the 16-bit pipelined core. It shares one synchronous block-RAM port between instruction fetch (IF) and the MEM-stage data access driven by the MemRead/MemWrite control signals. It issues one access at a time and waits out the RAM read latency. It returns read data with a one-cycle valid pulse and generates the pipeline stall signals for both stages.

---
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous block-RAM port between instruction fetch and MEM-stage data access.
// One access in flight at a time; reads wait out MEM_LAT and return data with a one-cycle valid pulse.
module mem_port_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [15:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [15:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        dbgState
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] RD_WAIT = 1'b1;
  localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

  // Handshake: a request is a level; it is accepted in the single cycle its gnt is high,
  // and only the addr/we/wdata present in that cycle are used.
  logic [0:0] state;
  logic [1:0] cnt;
  logic [1:0] streak;
  logic       ownerIf;
  logic       idle;
  logic       ifWin;
  logic       dWin;

  assign idle = (state == IDLE);

  // Data has priority, but after two data grants in a row with IF waiting, IF goes next.
  assign ifWin = idle & if_req & (~d_req | (streak == 2'd2));
  assign dWin  = idle & d_req & ~ifWin;

  assign if_gnt   = ifWin;
  assign d_gnt    = dWin;
  assign dbgState = state[0];

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ifWin) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
    end else if (dWin) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = d_req & ~(d_we ? d_gnt : d_valid);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      ownerIf  <= 1'b0;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (ifWin || (dWin && !d_we)) begin
            state   <= RD_WAIT;
            ownerIf <= ifWin;
            cnt     <= CNT_INIT;
          end
        end
        RD_WAIT: begin
          if (cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
          end else begin
            state <= IDLE;
            if (ownerIf) begin
              if_rdata <= mem_rdata;
              if_valid <= 1'b1;
            end else begin
              d_rdata <= mem_rdata;
              d_valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Streak of consecutive data grants while IF is waiting; saturates, never needs to exceed 2.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      streak <= '0;
    end else if (!if_req || ifWin) begin
      streak <= '0;
    end else if (dWin && (streak != 2'd3)) begin
      streak <= streak + 2'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LAT 1..3), each on its own RAM image,
// checked every cycle against a transaction-level model plus directed literal expectations.
module tb_mem_port_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst;
  logic [2:0] ifReq, dReq, dWe;
  logic [2:0][15:0] ifAddr, dAddr, dWdata;
  logic [2:0] ifGnt, ifValid, dGnt, dValid, memEn, memWe, stallIf, stallMem, dbgState;
  logic [2:0][15:0] ifRdata, dRdata, memAddr, memWdata;

  logic [15:0] ram [3][256];
  logic [15:0] pipe [3][5];

  for (genvar g = 0; g < 3; g++) begin : lane
    mem_port_arbiter #(.MEM_LAT(g + 1)) dut (
      .clock(clock), .reset(rst),
      .if_req(ifReq[g]), .if_addr(ifAddr[g]), .if_gnt(ifGnt[g]),
      .if_valid(ifValid[g]), .if_rdata(ifRdata[g]),
      .d_req(dReq[g]), .d_we(dWe[g]), .d_addr(dAddr[g]), .d_wdata(dWdata[g]),
      .d_gnt(dGnt[g]), .d_valid(dValid[g]), .d_rdata(dRdata[g]),
      .mem_en(memEn[g]), .mem_we(memWe[g]), .mem_addr(memAddr[g]),
      .mem_wdata(memWdata[g]), .mem_rdata(pipe[g][g + 1]),
      .stall_if(stallIf[g]), .stall_mem(stallMem[g]), .dbgState(dbgState[g])
    );
  end

  function automatic logic [15:0] ramInit(input logic [7:0] a);
    return (a == 8'h04) ? 16'h3A21 : {a, ~a};
  endfunction

  // Synchronous RAM environment: read data appears MEM_LAT cycles after the enable cycle.
  initial begin
    for (int l = 0; l < 3; l++) begin
      for (int a = 0; a < 256; a++) ram[l][a] <= ramInit(8'(a));
      for (int k = 0; k < 5; k++) pipe[l][k] <= 16'h0;
    end
    forever begin
      @(posedge clock);
      for (int l = 0; l < 3; l++) begin
        for (int k = 4; k >= 2; k--) pipe[l][k] <= pipe[l][k - 1];
        pipe[l][1] <= (memEn[l] && !memWe[l]) ? ram[l][memAddr[l][7:0]] : 16'hDEAD;
        if (memEn[l] && memWe[l]) ram[l][memAddr[l][7:0]] <= memWdata[l];
      end
    end
  end

  // Reference model: per lane, cycles left on the outstanding read, its owner and data.
  int          mRem [3];
  bit          mOwnIf [3];
  logic [15:0] mPend [3];
  int          mStreak [3];
  bit          mVIf [3], mVD [3];
  logic [15:0] mIfData [3], mDData [3];
  logic [15:0] mMem [3][256];
  bit          pIfWin [3], pDWin [3];

  int checks = 0;
  int failures = 0;
  int cycNo = 0;

  task automatic chk(input string name, input int l, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s lane%0d cycle %0d: got %h, want %h", name, l, cycNo, act, exp);
    end
  endtask

  task automatic chkBit(input string name, input int l, input logic act, input logic exp);
    chk(name, l, {15'h0, act}, {15'h0, exp});
  endtask

  task automatic modelReset(input int l);
    mRem[l] = 0; mOwnIf[l] = 0; mPend[l] = 16'h0; mStreak[l] = 0;
    mVIf[l] = 0; mVD[l] = 0; mIfData[l] = 16'h0; mDData[l] = 16'h0;
  endtask

  task automatic sample();
    logic expEn;
    @(negedge clock);
    for (int l = 0; l < 3; l++) begin
      if (rst) modelReset(l);
      pIfWin[l] = (mRem[l] == 0) && ifReq[l] && (!dReq[l] || mStreak[l] == 2);
      pDWin[l]  = (mRem[l] == 0) && dReq[l] && !pIfWin[l];
      expEn = pIfWin[l] || pDWin[l];
      chkBit("if_gnt", l, ifGnt[l], pIfWin[l]);
      chkBit("d_gnt", l, dGnt[l], pDWin[l]);
      chkBit("mem_en", l, memEn[l], expEn);
      chkBit("mem_we", l, memWe[l], pDWin[l] && dWe[l]);
      if (expEn) begin
        chk("mem_addr", l, memAddr[l], pIfWin[l] ? ifAddr[l] : dAddr[l]);
        chk("mem_wdata", l, memWdata[l], pIfWin[l] ? 16'h0 : dWdata[l]);
      end
      chkBit("if_valid", l, ifValid[l], mVIf[l]);
      chkBit("d_valid", l, dValid[l], mVD[l]);
      chk("if_rdata", l, ifRdata[l], mIfData[l]);
      chk("d_rdata", l, dRdata[l], mDData[l]);
      chkBit("stall_if", l, stallIf[l], ifReq[l] && !mVIf[l]);
      chkBit("stall_mem", l, stallMem[l], dReq[l] && !(dWe[l] ? pDWin[l] : mVD[l]));
      chkBit("busy_state", l, dbgState[l], mRem[l] != 0);
    end
  endtask

  task automatic advance();
    bit nvIf, nvD;
    for (int l = 0; l < 3; l++) begin
      if (rst) begin
        modelReset(l);
      end else begin
        nvIf = 0; nvD = 0;
        if (mRem[l] > 0) begin
          mRem[l]--;
          if (mRem[l] == 0) begin
            if (mOwnIf[l]) begin mIfData[l] = mPend[l]; nvIf = 1; end
            else begin mDData[l] = mPend[l]; nvD = 1; end
          end
        end else if (pIfWin[l]) begin
          mRem[l] = l + 1; mOwnIf[l] = 1; mPend[l] = mMem[l][ifAddr[l][7:0]];
        end else if (pDWin[l]) begin
          if (dWe[l]) mMem[l][dAddr[l][7:0]] = dWdata[l];
          else begin mRem[l] = l + 1; mOwnIf[l] = 0; mPend[l] = mMem[l][dAddr[l][7:0]]; end
        end
        if (!ifReq[l] || pIfWin[l]) mStreak[l] = 0;
        else if (pDWin[l] && mStreak[l] < 3) mStreak[l]++;
        mVIf[l] = nvIf; mVD[l] = nvD;
      end
    end
    @(posedge clock);
    #1;
    cycNo++;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic idleCycles(input int n);
    ifReq = '0; dReq = '0; dWe = '0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    int nG;
    rst = 1'b1;
    ifReq = '0; dReq = '0; dWe = '0; ifAddr = '0; dAddr = '0; dWdata = '0;
    for (int l = 0; l < 3; l++) begin
      modelReset(l);
      for (int a = 0; a < 256; a++) mMem[l][a] = ramInit(8'(a));
    end
    @(posedge clock);
    #1;
    cyc();
    cyc();
    rst = 1'b0;

    // Quiet after reset release: every output stays zero.
    for (int i = 0; i < 10; i++) begin
      sample();
      for (int l = 0; l < 3; l++) begin
        chk("reset_ctrl_zero", l, {7'h0, ifGnt[l], ifValid[l], dGnt[l], dValid[l], memEn[l],
            memWe[l], stallIf[l], stallMem[l], dbgState[l]}, 16'h0);
        chk("reset_rdata_zero", l, ifRdata[l] | dRdata[l], 16'h0);
        chk("reset_mem_zero", l, memAddr[l] | memWdata[l], 16'h0);
      end
      advance();
    end

    // Lane 0, MEM_LAT=1: single fetch of address 4.
    ifReq[0] = 1'b1; ifAddr[0] = 16'h0004;
    sample();
    chkBit("d1_if_gnt", 0, ifGnt[0], 1'b1);
    chkBit("d1_mem_en", 0, memEn[0], 1'b1);
    chkBit("d1_stall_T", 0, stallIf[0], 1'b1);
    advance();
    sample();
    chkBit("d1_stall_T1", 0, stallIf[0], 1'b1);
    chkBit("d1_mem_en_T1", 0, memEn[0], 1'b0);
    advance();
    sample();
    chkBit("d1_if_valid", 0, ifValid[0], 1'b1);
    chk("d1_if_rdata", 0, ifRdata[0], 16'h3A21);
    chkBit("d1_stall_T2", 0, stallIf[0], 1'b0);
    advance();
    idleCycles(6);

    // Lane 1, MEM_LAT=2: simultaneous fetch and load, data served first.
    ifReq[1] = 1'b1; ifAddr[1] = 16'h0008;
    dReq[1] = 1'b1; dWe[1] = 1'b0; dAddr[1] = 16'h0010;
    sample();
    chkBit("d2_d_gnt", 1, dGnt[1], 1'b1);
    chkBit("d2_if_wait", 1, ifGnt[1], 1'b0);
    advance();
    dReq[1] = 1'b0;
    cyc();
    cyc();
    sample();
    chkBit("d2_d_valid", 1, dValid[1], 1'b1);
    chk("d2_d_rdata", 1, dRdata[1], 16'h10EF);
    chkBit("d2_if_gnt", 1, ifGnt[1], 1'b1);
    advance();
    cyc();
    cyc();
    sample();
    chkBit("d2_if_valid", 1, ifValid[1], 1'b1);
    chk("d2_if_rdata", 1, ifRdata[1], 16'h08F7);
    advance();
    idleCycles(8);

    // Lane 0: continuous fetch against continuous stores, expect D,D,I repeating.
    ifReq[0] = 1'b1; ifAddr[0] = 16'h0002; dReq[0] = 1'b1; dWe[0] = 1'b1;
    nG = 0;
    for (int c = 0; c < 30 && nG < 9; c++) begin
      dAddr[0] = 16'h0040 + 16'(c);
      dWdata[0] = 16'($urandom);
      sample();
      if (ifGnt[0] || dGnt[0]) begin
        chkBit("d3_grant_is_if", 0, ifGnt[0], (nG % 3) == 2);
        if (dGnt[0]) chkBit("d3_stall_mem_store", 0, stallMem[0], 1'b0);
        nG++;
      end
      advance();
    end
    chk("d3_grant_count", 0, 16'(nG), 16'd9);
    idleCycles(6);

    // Lane 2, MEM_LAT=3: store then load back the same word.
    dReq[2] = 1'b1; dWe[2] = 1'b1; dAddr[2] = 16'h0020; dWdata[2] = 16'hBEEF;
    sample();
    chkBit("d5_store_gnt", 2, dGnt[2], 1'b1);
    chkBit("d5_store_we", 2, memWe[2], 1'b1);
    chkBit("d5_store_stall", 2, stallMem[2], 1'b0);
    advance();
    dWe[2] = 1'b0;
    sample();
    chkBit("d5_load_gnt", 2, dGnt[2], 1'b1);
    chkBit("d5_load_we", 2, memWe[2], 1'b0);
    advance();
    dReq[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      chkBit("d5_we_quiet", 2, memWe[2], 1'b0);
      chkBit("d5_no_early_valid", 2, dValid[2], 1'b0);
      advance();
    end
    sample();
    chkBit("d5_d_valid", 2, dValid[2], 1'b1);
    chk("d5_d_rdata", 2, dRdata[2], 16'hBEEF);
    advance();
    idleCycles(4);

    // Lane 2: reset one cycle into a load, then a fresh load.
    dReq[2] = 1'b1; dWe[2] = 1'b0; dAddr[2] = 16'h0012;
    sample();
    chkBit("d4_d_gnt", 2, dGnt[2], 1'b1);
    advance();
    dReq[2] = 1'b0;
    rst = 1'b1;
    sample();
    chkBit("d4_state_idle", 2, dbgState[2], 1'b0);
    chk("d4_rdata_cleared", 2, dRdata[2], 16'h0);
    advance();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sample();
      chkBit("d4_no_valid", 2, dValid[2], 1'b0);
      advance();
    end
    dReq[2] = 1'b1;
    sample();
    chkBit("d4_fresh_gnt", 2, dGnt[2], 1'b1);
    advance();
    dReq[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      chkBit("d4_fresh_wait", 2, dValid[2], 1'b0);
      advance();
    end
    sample();
    chkBit("d4_fresh_valid", 2, dValid[2], 1'b1);
    chk("d4_fresh_rdata", 2, dRdata[2], 16'h12ED);
    advance();
    idleCycles(4);

    // Randomized traffic on all lanes with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1; ifReq = '0; dReq = '0;
      end else begin
        rst = 1'b0;
        for (int l = 0; l < 3; l++) begin
          if ($urandom_range(0, 9) < 2) ifReq[l] = ~ifReq[l];
          if ($urandom_range(0, 9) < 3) dReq[l] = ~dReq[l];
          if ($urandom_range(0, 2) == 0) ifAddr[l] = {8'($urandom), 8'($urandom_range(0, 31))};
          if ($urandom_range(0, 2) == 0) begin
            dAddr[l] = {8'($urandom), 8'($urandom_range(0, 31))};
            dWe[l] = 1'($urandom);
            dWdata[l] = 16'($urandom);
          end
        end
      end
      cyc();
    end
    rst = 1'b0;
    idleCycles(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
